ula_multiciclo: RTL

//  Parametrised, handshaked ALU that succeeds the single-cycle datapath ALU.

---
 rtl/ula_multiciclo.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ula_multiciclo.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith/shift ops plus an
// iterative shift-add multiplier, with zero/carry/overflow/illegal flags.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready=1
// MUL   | shift-add iterations running, upstream stalled
// DONE  | result/flags presented, held until out_ready
module ula_multiciclo #(
  parameter int WIDTH      = 32,
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               illegal_q, illegal_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic [CW-1:0]    shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_o;
  logic             alu_ill;

  assign accept   = in_valid & in_ready;
  assign is_mul   = MUL_ENABLE && (op == OP_MUL);
  assign mul_last = (cnt_q == CW'(WIDTH - 1));
  assign shamt    = b[CW-1:0];
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = a - b;

  // Single-cycle datapath; opcode 1000 lands in default when MUL is disabled
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (a >= b);
        alu_o   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = is_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (mul_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (accept)         state_d = is_mul ? S_MUL : S_DONE;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Result/flag registers and multiplier iteration
  always_comb begin
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    acc_d      = acc_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    cnt_d      = cnt_q;
    if (accept) begin
      if (is_mul) begin
        a_sh_d = {{WIDTH{1'b0}}, a};
        b_sh_d = b;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        result_d   = alu_res;
        zero_d     = (alu_res == '0);
        carry_d    = alu_c;
        overflow_d = alu_o;
        illegal_d  = alu_ill;
      end
    end else if (state_q == S_MUL) begin
      acc_d  = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q + CW'(1);
      if (mul_last) begin
        result_d   = acc_d[WIDTH-1:0];
        zero_d     = (acc_d[WIDTH-1:0] == '0);
        carry_d    = 1'b0;
        overflow_d = |acc_d[2*WIDTH-1:WIDTH];
        illegal_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      acc_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      cnt_q      <= '0;
    end else begin
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      acc_q      <= acc_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      cnt_q      <= cnt_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;

endmodule
